split_register_sequencer: RTL and testbench
===========================================

Name: split_register_sequencer

Overview:
- Command sequencer for one split (two-half) register in the 8-bit datapath.
- Takes single commands over a valid/ready handshake: load, drive, clear, half-swap, increment and decrement.
- Converts each command into a one- or two-cycle sequence on the register's op_low/op_high and b-bus controls.
- Reads the register's always-visible state and drives the register's b-bus input itself, so INC/DEC/SWAP need no ALU or bus time.

Parameters:
HALF_WIDTH, 4, width of each register half; full register is 2*HALF_WIDTH bits.

Ports:
clk  in  1  system clock; sequencer state updates on posedge, register samples on negedge mid-cycle
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when sequencer is idle and can accept a command
cmd  in  3  command code, sampled when cmd_valid && cmd_ready
done  out  1  one-cycle pulse: command complete, register value settled
carry  out  1  wrap flag of last INC/DEC; valid with done, held until next accepted command
busy  out  1  high while a command is in progress
reg_value  in  2*HALF_WIDTH  register's always-on state output
op_low  out  reg_op_t  low-half register op
op_high  out  reg_op_t  high-half register op
bus_b_low  out  1  load low half from bus_b_out
bus_b_high  out  1  load high half from bus_b_out
bus_b_out  out  HALF_WIDTH  data driven to register's b-bus input

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE; op_low=op_high=REG_OP_NONE; bus_b_low=bus_b_high=0.
  - bus_b_out=0; temp=0; done=0; carry=0; busy=0; cmd_ready=1.
- Reset mid-command abandons the sequence. The register keeps any half already written; no rollback.
- All control outputs are registered, so they are stable over the negedge on which the register samples.
- States: IDLE, STEP0, STEP1.
  - cmd_ready = (state==IDLE).
  - busy = !cmd_ready.
- Acceptance: on a posedge with cmd_valid && cmd_ready, go to STEP0 and load the STEP0 outputs. These are computed from reg_value sampled at that same posedge.
- Completion: leaving the final step returns to IDLE with done=1 for exactly one cycle. A new command may be accepted on the same posedge that clears done, so back-to-back issue costs one idle cycle per command.
- Command codes:
  - 0 NOP, 7 reserved: STEP0 with all controls neutral, then done. carry unchanged.
  - 1 LOAD: STEP0 op_low=op_high=REG_OP_READ.
  - 2 DRIVE: STEP0 op_low=op_high=REG_OP_WRITE.
  - 3 CLEAR: STEP0 bus_b_low=bus_b_high=1, bus_b_out=0.
  - 4 SWAP:
    - At accept: temp<=reg_value low half; STEP0 bus_b_low=1, bus_b_out=reg_value high half.
    - STEP1: bus_b_high=1, bus_b_out=temp.
  - 5 INC:
    - STEP0: bus_b_low=1, bus_b_out=low+1 (mod 2^HALF_WIDTH). c0=(low==all ones).
    - If c0: STEP1 bus_b_high=1, bus_b_out=high+1. STEP1 uses the high half sampled at the end of STEP0, which is unchanged.
    - If !c0: done after STEP0.
    - carry = c0 && (high==all ones).
  - 6 DEC:
    - Same sequence as INC, but borrow c0=(low==0), low-1, high-1.
    - carry = c0 && (high==0).
- Outside active steps, every control is neutral: ops NONE, b strobes 0, bus_b_out holds its last value.
- Never drive op_low/op_high and a b-bus strobe on the same half in one cycle.
- cmd_valid while busy is ignored. The requester must hold the command until it is accepted.
- Latency from accept to done: 2 cycles for 1-step commands; 3 cycles for SWAP and carrying INC/DEC.

Test Plan:
- Reset with rst_n=0 mid-SWAP STEP0 -> all strobes drop asynchronously; cmd_ready=1, done=0, carry=0; register low half already written, high half untouched.
- reg=0x3A, SWAP -> STEP0 bus_b_low=1, bus_b_out=0x3; STEP1 bus_b_high=1, bus_b_out=0xA; reg=0xA3; done 3 cycles after accept.
- reg=0x2F, INC -> two steps, reg=0x30, carry=0. Then reg=0x24, INC -> one step, reg=0x25, done 2 cycles after accept.
- reg=0xFF, INC -> reg=0x00, carry=1. Then reg=0x00, DEC -> reg=0xFF, carry=1. Then DEC again -> reg=0xFE, carry=0.
- LOAD with bus_in=0x5C -> STEP0 op_low=op_high=REG_OP_READ, reg=0x5C. Then DRIVE -> both ops REG_OP_WRITE for one cycle, bus_out=0x5C.
- Back-to-back CLEAR, INC, NOP with cmd_valid held continuously -> each accepted on the done cycle of the prior command; cmd_valid pulses while busy are ignored; final reg=0x01, carry=0.

Source files
------------

// File: rtl/split_register_sequencer_pkg.sv
// split_register_sequencer_pkg: op codes shared by the split register and its sequencer
package split_register_sequencer_pkg;
  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;
endpackage

// File: rtl/split_register_sequencer.sv
// split_register_sequencer: turns single commands into op/b-bus strobe sequences for a split register
module split_register_sequencer
  import split_register_sequencer_pkg::*;
#(
  parameter int HALF_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd,
  output logic                    done,
  output logic                    carry,
  output logic                    busy,
  input  logic [2*HALF_WIDTH-1:0] reg_value,
  output reg_op_t                 op_low,
  output reg_op_t                 op_high,
  output logic                    bus_b_low,
  output logic                    bus_b_high,
  output logic [HALF_WIDTH-1:0]   bus_b_out
);
  localparam logic [1:0] S_IDLE = 2'd0, S_STEP0 = 2'd1, S_STEP1 = 2'd2;
  localparam logic [HALF_WIDTH-1:0] ONE = HALF_WIDTH'(1);
  logic [1:0]            r_state;
  logic [HALF_WIDTH-1:0] r_temp;
  logic                  r_two, r_swap, r_dec;
  logic [HALF_WIDTH-1:0] w_lo, w_hi;
  logic                  w_dec, w_c0, w_hi_wrap;
  assign w_lo      = reg_value[HALF_WIDTH-1:0];
  assign w_hi      = reg_value[2*HALF_WIDTH-1:HALF_WIDTH];
  assign w_dec     = cmd == 3'd6;
  assign w_c0      = w_dec ? (w_lo == '0) : (&w_lo);
  assign w_hi_wrap = w_dec ? (w_hi == '0) : (&w_hi);
  assign cmd_ready = r_state == S_IDLE;
  assign busy      = !cmd_ready;
  // STEP1 reads the untouched high half straight from reg_value, so no copy is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_temp     <= '0;
      r_two      <= 1'b0;
      r_swap     <= 1'b0;
      r_dec      <= 1'b0;
      done       <= 1'b0;
      carry      <= 1'b0;
      op_low     <= REG_OP_NONE;
      op_high    <= REG_OP_NONE;
      bus_b_low  <= 1'b0;
      bus_b_high <= 1'b0;
      bus_b_out  <= '0;
    end else begin
      done       <= 1'b0;
      op_low     <= REG_OP_NONE;
      op_high    <= REG_OP_NONE;
      bus_b_low  <= 1'b0;
      bus_b_high <= 1'b0;
      if (cmd_ready && cmd_valid) begin
        r_state <= S_STEP0;
        r_swap  <= cmd == 3'd4;
        r_dec   <= w_dec;
        r_two   <= (cmd == 3'd4) || ((cmd == 3'd5 || cmd == 3'd6) && w_c0);
        case (cmd)
          3'd1: begin op_low <= REG_OP_READ; op_high <= REG_OP_READ; end
          3'd2: begin op_low <= REG_OP_WRITE; op_high <= REG_OP_WRITE; end
          3'd3: begin bus_b_low <= 1'b1; bus_b_high <= 1'b1; bus_b_out <= '0; end
          3'd4: begin r_temp <= w_lo; bus_b_low <= 1'b1; bus_b_out <= w_hi; end
          3'd5, 3'd6: begin
            bus_b_low <= 1'b1;
            bus_b_out <= w_dec ? w_lo - ONE : w_lo + ONE;
            carry     <= w_c0 && w_hi_wrap;
          end
          default: ;
        endcase
      end else if (r_state == S_STEP0 && r_two) begin
        r_state    <= S_STEP1;
        bus_b_high <= 1'b1;
        bus_b_out  <= r_swap ? r_temp : r_dec ? w_hi - ONE : w_hi + ONE;
      end else if (!cmd_ready) begin
        r_state <= S_IDLE;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_split_register_sequencer.sv
// tb_split_register_sequencer: random and directed commands against a split-register model and a value-level reference
module tb_split_register_sequencer;
  import split_register_sequencer_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, done, carry, busy;
  logic [2:0] cmd;
  logic [7:0] reg_q;
  reg_op_t    op_low, op_high;
  logic       bus_b_low, bus_b_high;
  logic [3:0] bus_b_out;
  logic [7:0] bus_in, pl_val;
  logic       pl_en = 1'b0;
  logic       carry_m;
  int         checks = 0, failures = 0;
  int         n_bl = 0, n_bh = 0, n_rd = 0, n_wr = 0, n_bad = 0;
  logic [3:0] v_bl, v_bh;
  logic [7:0] v_wr;

  split_register_sequencer #(.HALF_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .done(done), .carry(carry), .busy(busy), .reg_value(reg_q),
    .op_low(op_low), .op_high(op_high), .bus_b_low(bus_b_low), .bus_b_high(bus_b_high),
    .bus_b_out(bus_b_out)
  );

  always #5 clk = ~clk;

  // split register: each half samples its op / b-bus strobe on the falling edge
  always @(negedge clk) begin
    if (pl_en) reg_q <= pl_val;
    else begin
      if (op_low == REG_OP_READ) reg_q[3:0] <= bus_in[3:0];
      if (bus_b_low) reg_q[3:0] <= bus_b_out;
      if (op_high == REG_OP_READ) reg_q[7:4] <= bus_in[7:4];
      if (bus_b_high) reg_q[7:4] <= bus_b_out;
    end
    if (bus_b_low) begin n_bl++; v_bl = bus_b_out; end
    if (bus_b_high) begin n_bh++; v_bh = bus_b_out; end
    if (op_low == REG_OP_READ) n_rd++;
    if (op_low == REG_OP_WRITE) begin n_wr++; v_wr = reg_q; end
    if ((op_low != REG_OP_NONE && bus_b_low) || (op_high != REG_OP_NONE && bus_b_high)) n_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    pl_val = v;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  // issue one command from an idle cycle and check it against the value-level rules
  task automatic run(input logic [2:0] c, input logic [7:0] bv, input bit hold, input bit chain);
    logic [7:0]  v0, ev;
    logic [3:0]  lo, hi;
    logic [15:0] ecnt;
    bit          c0;
    int          el, lat, s_bl, s_bh, s_rd, s_wr, s_bad;
    v0 = reg_q; lo = v0[3:0]; hi = v0[7:4];
    c0 = (c == 3'd5 && lo == 4'hF) || (c == 3'd6 && lo == 4'h0);
    ev = v0;
    case (c)
      3'd1: ev = bv;
      3'd3: ev = 8'h00;
      3'd4: ev = {lo, hi};
      3'd5: begin ev = v0 + 8'd1; carry_m = v0 == 8'hFF; end
      3'd6: begin ev = v0 - 8'd1; carry_m = v0 == 8'h00; end
      default: ;
    endcase
    el   = (c == 3'd4 || c0) ? 3 : 2;
    ecnt = {4'(c >= 3'd3 && c <= 3'd6), 4'(c == 3'd3 || c == 3'd4 || c0), 4'(c == 3'd1), 4'(c == 3'd2)};
    s_bl = n_bl; s_bh = n_bh; s_rd = n_rd; s_wr = n_wr; s_bad = n_bad;
    bus_in = bv; cmd = c; cmd_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!hold && !done) begin cmd_valid = 1'($urandom); cmd = 3'($urandom); end
    end while (!done && lat < 8);
    cmd_valid = chain;
    cmd = c;
    chk("lat", lat, el);
    chk("reg", reg_q, ev);
    chk("carry", carry, carry_m);
    chk("strobes", {4'(n_bl - s_bl), 4'(n_bh - s_bh), 4'(n_rd - s_rd), 4'(n_wr - s_wr)}, ecnt);
    chk("excl", n_bad - s_bad, 0);
    chk("ready", {cmd_ready, busy}, 2'b10);
    if (c == 3'd4) begin chk("swap_lo", v_bl, hi); chk("swap_hi", v_bh, lo); end
    if (c == 3'd2) chk("drive", v_wr, v0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; bus_in = 8'h00; pl_val = 8'h00; carry_m = 1'b0;
    reg_q = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {cmd_ready, busy, done, carry}, 4'b1000);
    chk("rst_out", {op_low, op_high, bus_b_low, bus_b_high, bus_b_out}, 10'h000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    preload(8'h3A); run(3'd4, 8'h00, 1'b0, 1'b0);
    preload(8'h2F); run(3'd5, 8'h00, 1'b0, 1'b0);
    preload(8'h24); run(3'd5, 8'h00, 1'b0, 1'b0);
    preload(8'hFF); run(3'd5, 8'h00, 1'b0, 1'b0);
    run(3'd6, 8'h00, 1'b0, 1'b0);
    run(3'd6, 8'h00, 1'b0, 1'b0);
    run(3'd1, 8'h5C, 1'b0, 1'b0);
    run(3'd2, 8'h00, 1'b0, 1'b0);
    preload(8'h77);
    run(3'd3, 8'h00, 1'b1, 1'b1);
    run(3'd5, 8'h00, 1'b1, 1'b1);
    run(3'd0, 8'h00, 1'b1, 1'b0);
    preload(8'hFF); run(3'd5, 8'h00, 1'b0, 1'b0);
    // reset lands after STEP0 has written the low half of a SWAP
    preload(8'h3A);
    cmd = 3'd4; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pre_rst_bl", bus_b_low, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {cmd_ready, busy, done, carry}, 4'b1000);
    chk("mid_rst_out", {op_low, op_high, bus_b_low, bus_b_high}, 6'h00);
    chk("mid_rst_reg", reg_q, 8'h33);
    carry_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_reg", reg_q, 8'h33);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) preload(8'($urandom));
      run(3'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
